// File: rtl/narnet_pkg.sv
// Shared types and defaults for the NARX network host sequencer.
package narnet_pkg;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned SAMPLE_W    = 8;
    localparam int unsigned DEF_WARMUP  = 16;
    localparam int unsigned DEF_PREDICT = 8;
    localparam int unsigned DEF_TIMEOUT = 255;

    // Signed S8.6 fixed-point sample
    typedef logic signed [SAMPLE_W-1:0] s8_6_t;
    typedef logic [CNT_W-1:0]           cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_FIN,
        ST_ERR
    } state_e;

endpackage

// File: rtl/narnet_edge_det.sv
// Rising-edge detector on a registered copy of the network's out_ready flag.
module narnet_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else if (enable) begin
            d_q <= d;
        end
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/narnet_host_seq.sv
// Host sequencer: open-loop warmup from the sample stream, then closed-loop prediction.
// Optional WAIT watchdog enabled by defining NARNET_TIMEOUT_EN.
module narnet_host_seq
    import narnet_pkg::*;
#(
    parameter int unsigned WARMUP  = DEF_WARMUP,
    parameter int unsigned PREDICT = DEF_PREDICT,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       start,
    input  logic                       s_valid,
    input  logic signed [SAMPLE_W-1:0] s_data,
    output logic                       s_ready,
    output logic signed [SAMPLE_W-1:0] x_in,
    output logic                       x_ready,
    input  logic signed [SAMPLE_W-1:0] y_out,
    input  logic                       out_ready,
    output logic                       m_valid,
    output logic signed [SAMPLE_W-1:0] m_data,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam cnt_t WARM_N   = CNT_W'(WARMUP);
    localparam cnt_t PRED_N   = CNT_W'(PREDICT);
    localparam cnt_t TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e state_q, state_n;
    cnt_t   warm_q, warm_n;
    cnt_t   pred_q, pred_n;
    logic   fb_q, fb_n;
    s8_6_t  x_q, x_n;
    s8_6_t  y_q, y_n;
    logic   or_rise_c;
    logic   s_ready_n, x_ready_n, m_valid_n, m_last_n, busy_n, done_n, err_n;

`ifdef NARNET_TIMEOUT_EN
    cnt_t   tmo_q, tmo_n;
`else
    logic   unused_tmo;
    assign  unused_tmo = ^TMO_LAST;
`endif

    narnet_edge_det u_edge (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .d      (out_ready),
        .rise_c (or_rise_c)
    );

    assign x_in   = x_q;
    assign m_data = y_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_n = state_q;
        warm_n  = warm_q;
        pred_n  = pred_q;
        fb_n    = fb_q;
        x_n     = x_q;
        y_n     = y_q;
`ifdef NARNET_TIMEOUT_EN
        tmo_n   = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    warm_n  = '0;
                    pred_n  = '0;
                    fb_n    = 1'b0;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (warm_q < WARM_N) begin
                    if (s_valid && s_ready) begin
                        x_n     = s_data;
                        warm_n  = warm_q + cnt_t'(1);
                        state_n = ST_ISSUE;
                    end
                end else begin
                    // closed loop: previous prediction becomes the next input
                    x_n     = y_q;
                    fb_n    = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!out_ready) begin
                    state_n = ST_WAIT;
`ifdef NARNET_TIMEOUT_EN
                    tmo_n   = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (or_rise_c) begin
                    y_n     = y_out;
                    if (fb_q) begin
                        pred_n = pred_q + cnt_t'(1);
                    end
                    state_n = ST_EMIT;
                end
`ifdef NARNET_TIMEOUT_EN
                else if (tmo_q >= TMO_LAST) begin
                    state_n = ST_ERR;
                end else begin
                    tmo_n = tmo_q + cnt_t'(1);
                end
`endif
            end
            ST_EMIT: begin
                if (m_ready) begin
                    state_n = ((warm_q == WARM_N) && (pred_q == PRED_N)) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FIN: begin
                state_n = ST_IDLE;
            end
            ST_ERR: begin
`ifdef NARNET_TIMEOUT_EN
                state_n = ST_ERR;
`else
                state_n = ST_IDLE;
`endif
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        s_ready_n = (state_n == ST_FETCH) && (warm_n < WARM_N);
        x_ready_n = (state_q == ST_ISSUE) && (state_n == ST_WAIT);
        m_valid_n = (state_n == ST_EMIT);
        m_last_n  = (state_n == ST_EMIT) && (warm_n == WARM_N) && (pred_n == PRED_N);
        busy_n    = (state_n != ST_IDLE);
        done_n    = (state_n == ST_FIN);
`ifdef NARNET_TIMEOUT_EN
        err_n     = (state_n == ST_ERR);
`else
        err_n     = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
            pred_q  <= '0;
            fb_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            s_ready <= 1'b0;
            x_ready <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef NARNET_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else if (enable) begin
            state_q <= state_n;
            warm_q  <= warm_n;
            pred_q  <= pred_n;
            fb_q    <= fb_n;
            x_q     <= x_n;
            y_q     <= y_n;
            s_ready <= s_ready_n;
            x_ready <= x_ready_n;
            m_valid <= m_valid_n;
            m_last  <= m_last_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
`ifdef NARNET_TIMEOUT_EN
            tmo_q   <= tmo_n;
`endif
        end
    end

endmodule

// File: doc/narnet_host_seq.md
NARNET_HOST_SEQ -- requirements
Module: narnet_host_seq

Interface
REQ-001 SHALL have parameter WARMUP, default 16: open-loop samples taken from the input stream per run (1..255).
REQ-002 SHALL have parameter PREDICT, default 8: closed-loop predictions per run (0..255).
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for out_ready (only used with NARNET_TIMEOUT_EN).
REQ-004 Port clk, input, 1: the single clock. All logic is on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port enable, input, 1: when low, all state, counters and outputs hold.
REQ-007 Port start, input, 1: one-cycle request to begin a run.
REQ-008 Ports s_valid input 1, s_data input 8 signed, s_ready output 1: input sample stream.
REQ-009 Ports x_in output 8 signed, x_ready output 1: sample and strobe to the network.
REQ-010 Ports y_out input 8 signed, out_ready input 1: result and flag from the network.
REQ-011 Ports m_valid output 1, m_data output 8 signed, m_ready input 1, m_last output 1: result stream.
REQ-012 Ports busy output 1, done output 1, err output 1: status.

Function
REQ-013 States: IDLE, FETCH, ISSUE, WAIT, EMIT, FIN, ERR.
- IDLE: busy=0. On start=1, clear both counters and go to FETCH.
- A start that arrives while busy SHALL be ignored.
REQ-014 FETCH, while fewer than WARMUP samples have been used:
- s_ready=1.
- When s_valid&&s_ready, latch s_data into the x register, increment the warmup counter, and go to ISSUE.
- s_ready SHALL be 0 in every other state.
REQ-015 FETCH, once the warmup counter equals WARMUP:
- Load the x register with the last captured y value (closed-loop feedback) with no stream access.
- Go to ISSUE.
REQ-016 ISSUE:
- Wait until out_ready is sampled 0, so the network has returned to its wait state.
- Then drive x_ready=1 for exactly one cycle and go to WAIT.
REQ-017 x_in SHALL equal the x register at all times and stay stable from ISSUE until out_ready is captured.
REQ-018 WAIT:
- On the first cycle out_ready=1, capture y_out into the y register.
- If the run is now in the prediction phase, increment the prediction counter.
- Go to EMIT.
- A repeated high out_ready SHALL NOT be counted twice; rising-edge detect on a registered copy of out_ready.
REQ-019 EMIT:
- m_valid=1 and m_data=y register until m_ready=1.
- m_last=1 only on the final result of the run.
- After the handshake: go to FIN if WARMUP+PREDICT results have been emitted, else go to FETCH.
REQ-020 FIN: done=1 for one cycle, then IDLE.
REQ-021 Total results per run = WARMUP+PREDICT.
- All open-loop results are emitted, not only the predictions.
- PREDICT=0 gives a pure open-loop run.
REQ-022 Latency, ISSUE to x_ready: 1 cycle when out_ready is already 0.
REQ-023 Counters SHALL be 8-bit unsigned and SHALL NOT wrap within a run.
REQ-024 busy=1 in every state except IDLE.

Reset
REQ-025 On rst=1, which takes precedence over enable:
- State returns to IDLE.
- Counters, x register, y register and the edge register are cleared to 0.
- s_ready, x_ready, m_valid, m_last, done, err and busy are 0.
REQ-026 Reset mid-run SHALL abort without emitting a partial result.

Configuration
REQ-027 Macro NARNET_TIMEOUT_EN, defined:
- A cycle counter runs in WAIT.
- If out_ready does not rise within TIMEOUT cycles, go to ERR.
- ERR: err=1 until rst; start is ignored.
REQ-028 Macro NARNET_TIMEOUT_EN, undefined:
- No timeout counter; WAIT waits indefinitely.
- err is tied to 0 and ERR is unreachable.

Structure
REQ-029 A shared package narnet_pkg SHALL hold:
- The state enumeration.
- The 8-bit signed sample type (S8.6).
- The default WARMUP/PREDICT/TIMEOUT constants.
REQ-030 One sub-module, narnet_edge_det, SHALL provide rising-edge detection of out_ready; everything else is flat.

Verification
REQ-031 WARMUP=2, PREDICT=1, behavioural network model returning y=x+1:
- Stream in 10, 20.
- m_data sequence SHALL be 11, 21, 22, with m_last only on 22 and one done pulse.
REQ-032 Backpressure: hold m_ready=0 for 5 cycles.
- m_valid stays 1 and m_data stays stable.
- No new x_ready is issued.
REQ-033 out_ready held high for 3 cycles:
- Exactly one capture occurs.
- The next x_ready is issued only after out_ready falls.
REQ-034 start pulsed while busy: no effect, and the result count is unchanged.
REQ-035 rst asserted in WAIT:
- Next cycle all outputs are 0 and the state is IDLE.
- A following start runs normally.
REQ-036 NARNET_TIMEOUT_EN defined, TIMEOUT=10, network model never asserts out_ready:
- err=1 by cycle 11 after x_ready.
- err is cleared only by rst.
